// File: rtl/bram_dp_be.sv
// Simple-dual-port block RAM with byte enables, selectable read-during-write
// policy, optional output register, read-valid strobe and sticky range error.
module bram_dp_be #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned BIT_WIDTH  = 32,
  parameter int unsigned READ_PIPE  = 0,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [BIT_WIDTH/8-1:0] wbe,
  input  logic [ADDR_WIDTH-1:0]  waddr,
  input  logic [BIT_WIDTH-1:0]   wdi,
  input  logic                   re,
  input  logic [ADDR_WIDTH-1:0]  raddr,
  output logic [BIT_WIDTH-1:0]   rdo,
  output logic                   rvalid,
  output logic                   oor_err
);

  localparam int unsigned NB    = BIT_WIDTH / 8;
  localparam int unsigned AW1   = ADDR_WIDTH + 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BIT_WIDTH-1:0] mem [DEPTH];

  logic             waddr_ok_c, raddr_ok_c, w_ok_c, r_ok_c, coll_c;
  logic [IDX_W-1:0] widx_c, ridx_c;
  logic [BIT_WIDTH-1:0] rd_c;

  // Full-width unsigned compare, so DEPTH+k never aliases onto entry k
  assign waddr_ok_c = ({1'b0, waddr} < AW1'(DEPTH));
  assign raddr_ok_c = ({1'b0, raddr} < AW1'(DEPTH));
  assign w_ok_c     = we && waddr_ok_c;
  assign r_ok_c     = re && raddr_ok_c;
  assign widx_c     = waddr[IDX_W-1:0];
  assign ridx_c     = raddr[IDX_W-1:0];
  assign coll_c     = w_ok_c && r_ok_c && (waddr == raddr);

  // Array storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (w_ok_c) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) mem[widx_c][8*i +: 8] <= wdi[8*i +: 8];
      end
    end
  end

  // Read word; out-of-range reads return zero, write-first merge on collision
  always_comb begin
    rd_c = '0;
    if (r_ok_c) begin
      rd_c = mem[ridx_c];
      if ((BYPASS != 0) && coll_c) begin
        for (int i = 0; i < NB; i++) begin
          if (wbe[i]) rd_c[8*i +: 8] = wdi[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oor_err <= 1'b0;
    end else if ((we && !waddr_ok_c) || (re && !raddr_ok_c)) begin
      oor_err <= 1'b1;
    end
  end

  generate
    if (READ_PIPE != 0) begin : g_pipe
      logic [BIT_WIDTH-1:0] p_data;
      logic                 p_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          p_data  <= '0;
          p_valid <= 1'b0;
          rdo     <= '0;
          rvalid  <= 1'b0;
        end else begin
          p_valid <= re;
          if (re) p_data <= rd_c;
          rvalid <= p_valid;
          if (p_valid) rdo <= p_data;
        end
      end
    end else begin : g_nopipe
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdo    <= '0;
          rvalid <= 1'b0;
        end else begin
          rvalid <= re;
          if (re) rdo <= rd_c;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_bram_dp_be.sv
// Directed bench for bram_dp_be: three instances share stimulus
// (defaults, read-first, and two-stage read pipeline).
module tb_bram_dp_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [3:0]  wbe;
  logic [11:0] waddr;
  logic [31:0] wdi;
  logic        re;
  logic [11:0] raddr;

  logic [31:0] rdo0, rdo1, rdo2;
  logic        rvalid0, rvalid1, rvalid2;
  logic        oor0, oor1, oor2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_dp_be u_def (
    .clk(clk), .rst(rst), .we(we), .wbe(wbe), .waddr(waddr), .wdi(wdi),
    .re(re), .raddr(raddr), .rdo(rdo0), .rvalid(rvalid0), .oor_err(oor0)
  );

  bram_dp_be #(.BYPASS(0)) u_rf (
    .clk(clk), .rst(rst), .we(we), .wbe(wbe), .waddr(waddr), .wdi(wdi),
    .re(re), .raddr(raddr), .rdo(rdo1), .rvalid(rvalid1), .oor_err(oor1)
  );

  bram_dp_be #(.READ_PIPE(1)) u_rp (
    .clk(clk), .rst(rst), .we(we), .wbe(wbe), .waddr(waddr), .wdi(wdi),
    .re(re), .raddr(raddr), .rdo(rdo2), .rvalid(rvalid2), .oor_err(oor2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    we = 1'b1; waddr = a; wdi = d; wbe = be;
    tick();
    we = 1'b0; wbe = 4'h0;
  endtask

  task automatic do_read(input logic [11:0] a);
    re = 1'b1; raddr = a;
    tick();
    re = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; wbe = 4'h0; waddr = '0; wdi = '0; re = 1'b0; raddr = '0;
    tick(); tick();
    checks++;
    if (rdo0 !== 32'h0 || rvalid0 !== 1'b0 || oor0 !== 1'b0) begin
      errors++; $display("FAIL reset_def rdo=%h rvalid=%b oor=%b expected 0/0/0", rdo0, rvalid0, oor0);
    end
    checks++;
    if (rdo1 !== 32'h0 || rvalid1 !== 1'b0 || oor1 !== 1'b0) begin
      errors++; $display("FAIL reset_rf rdo=%h rvalid=%b oor=%b expected 0/0/0", rdo1, rvalid1, oor1);
    end
    checks++;
    if (rdo2 !== 32'h0 || rvalid2 !== 1'b0 || oor2 !== 1'b0) begin
      errors++; $display("FAIL reset_rp rdo=%h rvalid=%b oor=%b expected 0/0/0", rdo2, rvalid2, oor2);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_defaults();
    do_write(12'd3, 32'hDEADBEEF, 4'hF);
    do_read(12'd3);
    checks++;
    if (rdo0 !== 32'hDEADBEEF || rvalid0 !== 1'b1) begin
      errors++; $display("FAIL def_read rdo=%h rvalid=%b expected deadbeef/1", rdo0, rvalid0);
    end
    checks++;
    if (rdo1 !== 32'hDEADBEEF || rvalid1 !== 1'b1) begin
      errors++; $display("FAIL rf_read rdo=%h rvalid=%b expected deadbeef/1", rdo1, rvalid1);
    end
    checks++;
    if (rvalid2 !== 1'b0) begin
      errors++; $display("FAIL rp_early rvalid=%b expected 0", rvalid2);
    end
    tick();
    checks++;
    if (rdo0 !== 32'hDEADBEEF || rvalid0 !== 1'b0) begin
      errors++; $display("FAIL def_hold rdo=%h rvalid=%b expected deadbeef/0", rdo0, rvalid0);
    end
    checks++;
    if (rdo2 !== 32'hDEADBEEF || rvalid2 !== 1'b1) begin
      errors++; $display("FAIL rp_lat2 rdo=%h rvalid=%b expected deadbeef/1", rdo2, rvalid2);
    end
    tick();
    checks++;
    if (rdo2 !== 32'hDEADBEEF || rvalid2 !== 1'b0) begin
      errors++; $display("FAIL rp_hold rdo=%h rvalid=%b expected deadbeef/0", rdo2, rvalid2);
    end
  endtask

  task automatic test_byte_enables();
    do_write(12'd5, 32'h11223344, 4'hF);
    do_write(12'd5, 32'hAABBCCDD, 4'b0101);
    do_write(12'd6, 32'h55555555, 4'h0);
    do_read(12'd5);
    checks++;
    if (rdo0 !== 32'h11BB33DD || rvalid0 !== 1'b1) begin
      errors++; $display("FAIL byte_en rdo=%h rvalid=%b expected 11bb33dd/1", rdo0, rvalid0);
    end
    do_write(12'd6, 32'h600DF00D, 4'hF);
    do_write(12'd6, 32'h55555555, 4'h0);
    do_read(12'd6);
    checks++;
    if (rdo0 !== 32'h600DF00D) begin
      errors++; $display("FAIL wbe_zero rdo=%h expected 600df00d", rdo0);
    end
  endtask

  task automatic test_collision();
    do_write(12'd7, 32'h0, 4'hF);
    we = 1'b1; waddr = 12'd7; wdi = 32'hCAFEF00D; wbe = 4'b0011;
    re = 1'b1; raddr = 12'd7;
    tick();
    we = 1'b0; wbe = 4'h0; re = 1'b0;
    checks++;
    if (rdo0 !== 32'h0000F00D) begin
      errors++; $display("FAIL coll_bypass rdo=%h expected 0000f00d", rdo0);
    end
    checks++;
    if (rdo1 !== 32'h00000000) begin
      errors++; $display("FAIL coll_readfirst rdo=%h expected 00000000", rdo1);
    end
    tick();
    checks++;
    if (rdo2 !== 32'h0000F00D || rvalid2 !== 1'b1) begin
      errors++; $display("FAIL coll_pipe rdo=%h rvalid=%b expected 0000f00d/1", rdo2, rvalid2);
    end
    do_read(12'd7);
    checks++;
    if (rdo0 !== 32'h0000F00D || rdo1 !== 32'h0000F00D) begin
      errors++; $display("FAIL coll_after rdo_def=%h rdo_rf=%h expected 0000f00d", rdo0, rdo1);
    end
  endtask

  task automatic test_out_of_range();
    do_write(12'd0, 32'hA5A5A5A5, 4'hF);
    checks++;
    if (oor0 !== 1'b0) begin
      errors++; $display("FAIL oor_clear oor=%b expected 0", oor0);
    end
    do_write(12'd16, 32'h12345678, 4'hF);
    checks++;
    if (oor0 !== 1'b1 || oor2 !== 1'b1) begin
      errors++; $display("FAIL oor_write oor_def=%b oor_rp=%b expected 1", oor0, oor2);
    end
    do_read(12'd16);
    checks++;
    if (rdo0 !== 32'h0 || rvalid0 !== 1'b1 || oor0 !== 1'b1) begin
      errors++; $display("FAIL oor_read rdo=%h rvalid=%b oor=%b expected 0/1/1", rdo0, rvalid0, oor0);
    end
    tick(); tick();
    checks++;
    if (oor0 !== 1'b1 || oor1 !== 1'b1) begin
      errors++; $display("FAIL oor_sticky oor_def=%b oor_rf=%b expected 1", oor0, oor1);
    end
    do_read(12'd0);
    checks++;
    if (rdo0 !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL oor_alias rdo=%h expected a5a5a5a5", rdo0);
    end
    do_read(12'hFFF);
    checks++;
    if (rdo1 !== 32'h0 || rvalid1 !== 1'b1) begin
      errors++; $display("FAIL oor_max rdo=%h rvalid=%b expected 0/1", rdo1, rvalid1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int i = 0; i < 16; i++) do_write(12'(i), 32'(i) * 32'h01010101, 4'hF);
    tick();
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin
        re = 1'b1; raddr = 12'(k);
      end else begin
        re = 1'b0;
      end
      tick();
      checks++;
      if (k >= 1 && k <= 16) begin
        exp = 32'(k - 1) * 32'h01010101;
        if (rvalid2 !== 1'b1 || rdo2 !== exp) begin
          errors++; $display("FAIL stream_%0d rdo=%h rvalid=%b expected %h/1", k, rdo2, rvalid2, exp);
        end
      end else if (rvalid2 !== 1'b0) begin
        errors++; $display("FAIL stream_edge_%0d rvalid=%b expected 0", k, rvalid2);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    do_read(12'd3);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (rvalid2 !== 1'b0 || rdo2 !== 32'h0) begin
      errors++; $display("FAIL rst_async_rp rdo=%h rvalid=%b expected 0/0", rdo2, rvalid2);
    end
    checks++;
    if (rvalid0 !== 1'b0 || rdo0 !== 32'h0 || oor0 !== 1'b0) begin
      errors++; $display("FAIL rst_async_def rdo=%h rvalid=%b oor=%b expected 0/0/0", rdo0, rvalid0, oor0);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (rvalid2 !== 1'b0) begin
        errors++; $display("FAIL rst_ghost_%0d rvalid=%b expected 0", k, rvalid2);
      end
    end
    do_read(12'd3);
    tick();
    checks++;
    if (rdo2 !== 32'h03030303 || rvalid2 !== 1'b1) begin
      errors++; $display("FAIL rst_retain rdo=%h rvalid=%b expected 03030303/1", rdo2, rvalid2);
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_byte_enables();
    test_collision();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_dp_be.md
Name: bram_dp_be

Overview:
- Parametrised simple-dual-port block RAM: one write port, one read port, one clock.
- Adds to the plain 16-entry BRAM:
  - per-byte write enables
  - selectable read-during-write policy
  - optional output register stage
  - read-valid strobe
  - out-of-range address detection
- Used as coefficient/tap/data storage inside user-project accelerators, where read latency and same-address collisions must be deterministic.

Parameters:
- ADDR_WIDTH, 12, width of waddr/raddr.
- DEPTH, 16, number of words; legal addresses 0..DEPTH-1; DEPTH <= 2**ADDR_WIDTH.
- BIT_WIDTH, 32, word width; must be a multiple of 8.
- READ_PIPE, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2 cycles.
- BYPASS, 1, 1 = write-first forwarding on same-address collision; 0 = read-first (old data).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write request.
- wbe  input  BIT_WIDTH/8  byte enables; bit i covers wdi[8i+7:8i].
- waddr  input  ADDR_WIDTH  write address.
- wdi  input  BIT_WIDTH  write data.
- re  input  1  read request.
- raddr  input  ADDR_WIDTH  read address.
- rdo  output  BIT_WIDTH  read data (registered).
- rvalid  output  1  one-cycle strobe marking rdo as updated by a read.
- oor_err  output  1  sticky flag: some access used an address >= DEPTH.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - rdo=0, rvalid=0, oor_err=0, pipeline stage registers cleared.
  - Array contents are NOT reset; power-up contents are undefined.
- Write:
  - Takes effect when we=1 and waddr<DEPTH.
  - Each byte i with wbe[i]=1 is written; the other bytes keep their value.
  - we=1 with wbe all-zero is a no-op.
- Read:
  - Registered when re=1 and raddr<DEPTH.
  - READ_PIPE=0: rdo and rvalid update at edge N+1 for a request at edge N.
  - READ_PIPE=1: rdo and rvalid update at edge N+2.
  - Back-to-back reads give one result per cycle; full throughput, no stalls.
- rvalid is 1 exactly in the cycle its rdo is first presented. rdo holds its last value when no read completes.
- Collision (we=1, re=1, waddr==raddr, both in range, same cycle):
  - BYPASS=1: rdo = merged word. Bytes with wbe set come from wdi; the rest are old array content.
  - BYPASS=0: rdo = old array content. The write still completes.
  - Reads in later cycles always see the written data.
- Out of range (address >= DEPTH):
  - Write is ignored; array is unchanged.
  - Read still produces rvalid with rdo=0.
  - oor_err is set on the next edge and stays set until rst.
- Reset mid-operation: in-flight reads in the pipeline are discarded; no rvalid is issued after reset deasserts for requests made before it.
- Arithmetic/width:
  - Address compare is unsigned over the full ADDR_WIDTH.
  - No wrap-around: an address like DEPTH+k never aliases to entry k.

Test Plan:
- Defaults. Write 0xDEADBEEF @3 (wbe=4'hF), then re @3 -> rdo=0xDEADBEEF and rvalid=1 exactly one cycle after re; rdo holds afterwards with rvalid=0.
- Byte enables. Write 0x11223344 @5, then write 0xAABBCCDD @5 with wbe=4'b0101, then read @5 -> rdo=0x11BB33DD.
- Collision. @7 holds 0x00000000; same cycle we=1 (wdi=0xCAFEF00D, wbe=4'b0011), re=1, both @7:
  - BYPASS=1 -> rdo=0x0000F00D.
  - BYPASS=0 -> rdo=0x00000000.
  - Next read @7 -> 0x0000F00D in both cases.
- READ_PIPE=1 streaming. Reads @0..@15 on consecutive cycles (mem[i]=i*0x01010101) -> rvalid high for 16 consecutive cycles starting 2 cycles after the first re, with rdo=i*0x01010101 in order.
- Out of range (DEPTH=16). Write 0x12345678 @16, then read @16 -> rdo=0, rvalid=1, oor_err=1 and stays 1. Read @0 is unaffected by the bad write.
- Reset mid-read (READ_PIPE=1). Assert rst one cycle after re -> rvalid=0, rdo=0 immediately (async). No rvalid appears after deassertion. Array data written before reset is still readable.
